mnist_batch_driver: RTL and testbench
=====================================

MNIST_BATCH_DRIVER -- requirements
Module: mnist_batch_driver

Interface
REQ-001 The block SHALL have parameter NUM_IMAGES, default 1000: images per batch.
REQ-002 The block SHALL have parameter PIXELS, default 784: 1-bit pixels per image.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 200000: prediction watchdog limit.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-005 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin batch, level-sampled.
- img_addr  out  20  bit address into the image ROM.
- img_bit  in  1  ROM data, valid 1 cycle after img_addr.
- lbl_addr  out  10  label ROM address.
- lbl_data  in  4  label, valid 1 cycle after lbl_addr.
- data_out  out  1  pixel to the classifier data_in.
- valid_out  out  1  pixel qualifier to the classifier valid_in.
- pred_in  in  4  classifier prediction.
- pred_valid  in  1  classifier valid_out, 1-cycle pulse.
- hit_count  out  10  correct predictions.
- img_count  out  10  images completed.
- timeout_count  out  10  images ended by the watchdog.
- busy  out  1  batch in progress.
- done  out  1  batch finished, held.

Function
REQ-006 The FSM SHALL have states IDLE, STREAM, WAIT, CHECK and DONE.
REQ-007 IDLE->STREAM SHALL occur when start=1; on entry img_count, hit_count and timeout_count clear, the image index becomes 0 and busy becomes 1.
REQ-008 STREAM SHALL drive img_addr = idx*PIXELS + p for p=0..PIXELS-1 on consecutive cycles with no gaps.
REQ-009 valid_out SHALL be registered, asserted for exactly PIXELS consecutive cycles, with the first assertion 2 cycles after STREAM entry.
REQ-010 data_out SHALL equal the ROM bit for the corresponding address.
REQ-011 STREAM->WAIT SHALL occur after the last address is issued; valid_out SHALL drop immediately after its PIXELS-th cycle.
REQ-012 lbl_addr SHALL equal idx from STREAM entry until CHECK exits; the label SHALL be sampled into a register by the end of STREAM.
REQ-013 In WAIT, pred_valid=1 SHALL capture pred_in and transition the FSM to CHECK.
REQ-014 pred_valid SHALL be ignored in every state other than WAIT.
REQ-015 A pred_valid pulse that coincides with the last valid_out cycle SHALL be ignored, because the FSM is not yet in WAIT.
REQ-016 CHECK SHALL last 1 cycle: hit_count increments if the captured prediction equals the label, and img_count increments unconditionally.
REQ-017 CHECK->DONE SHALL occur when img_count reaches NUM_IMAGES; otherwise idx increments and the FSM enters STREAM.
REQ-018 DONE SHALL hold done=1, busy=0 and all counters.
REQ-019 start=1 in DONE SHALL re-enter STREAM with counters cleared, with the same behaviour as IDLE->STREAM.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 Counters SHALL be 10-bit unsigned; NUM_IMAGES<=1023 SHALL be guaranteed by the parameter, so no wrap occurs.
REQ-022 img_addr SHALL be computed without overflow for NUM_IMAGES*PIXELS <= 2^20.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE.
REQ-024 During reset, all outputs SHALL be 0: img_addr, lbl_addr, data_out, valid_out, counters, busy and done.
REQ-025 Reset mid-STREAM SHALL drop valid_out in the same instant, and no partial image SHALL be counted.
REQ-026 After reset release, the block SHALL remain in IDLE until start=1.

Configuration
REQ-027 With BATCH_WATCHDOG_EN defined, a WAIT-cycle counter SHALL clear on WAIT entry; on reaching TIMEOUT_CYCLES the FSM SHALL enter CHECK, the image SHALL be scored as a miss, and timeout_count SHALL increment.
REQ-028 Without BATCH_WATCHDOG_EN, WAIT SHALL persist until pred_valid, and timeout_count SHALL be held at 0.

Verification (NUM_IMAGES=4, PIXELS=8, TIMEOUT_CYCLES=50)
REQ-029 Reset, then start pulse: valid_out SHALL be high for exactly 8 cycles with data_out matching ROM bits 0..7, img_addr SHALL run 0..7, and the first valid SHALL come 2 cycles after STREAM entry.
REQ-030 Model returning labels {3,7,1,0} against predictions {3,2,1,0}: done=1, hit_count=3, img_count=4.
REQ-031 pred_valid pulsed during STREAM and again in WAIT: only the WAIT pulse SHALL be scored, with img_count stepping by 1.
REQ-032 rst_n low at pixel 5 of image 2: all outputs SHALL be 0 at once; a subsequent start SHALL restart from img_addr=0 with counters 0.
REQ-033 With the watchdog enabled and no pred_valid for image 1: after 50 WAIT cycles timeout_count=1, the image SHALL be a miss, and streaming SHALL resume at img_addr=16.
REQ-034 start held high in DONE: a new batch SHALL begin and counters SHALL clear; start held during STREAM SHALL have no effect.

Source files
------------

// File: rtl/mnist_batch_driver.sv
// mnist_batch_driver: streams 1-bit MNIST images from ROM to a classifier and scores predictions.
// Optional prediction watchdog enabled by defining BATCH_WATCHDOG_EN.
module mnist_batch_driver #(
  parameter int NUM_IMAGES     = 1000,
  parameter int PIXELS         = 784,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [19:0] img_addr,
  input  logic        img_bit,
  output logic [9:0]  lbl_addr,
  input  logic [3:0]  lbl_data,
  output logic        data_out,
  output logic        valid_out,
  input  logic [3:0]  pred_in,
  input  logic        pred_valid,
  output logic [9:0]  hit_count,
  output logic [9:0]  img_count,
  output logic [9:0]  timeout_count,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(PIXELS + 2);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef BATCH_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, STREAM, WAIT, CHECK, DONE
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_off;
  logic [19:0]   r_base;
  logic [9:0]    r_idx;
  logic [3:0]    r_label;
  logic [3:0]    r_pred;
  logic          r_to;
  logic [WW-1:0] r_wd;
  logic          r_rd_v;
  logic          r_valid;
  logic          r_data;
  logic [9:0]    r_hit;
  logic [9:0]    r_img;
  logic [9:0]    r_tmo;
  logic          w_start;
  logic          w_last;
  logic          w_wd_hit;
  logic          w_str_end;

  // STREAM covers the address phase plus two drain cycles of the pixel pipe
  assign w_str_end = (r_cnt == CW'(PIXELS + 1));
  assign w_start   = start && (r_state == IDLE || r_state == DONE);
  assign w_last    = (r_img + 10'd1 == 10'(NUM_IMAGES));
  assign w_wd_hit  = WD_EN && (r_state == WAIT)
                     && (r_wd == WW'(TIMEOUT_CYCLES - 1));
  assign w_off     = (r_cnt < CW'(PIXELS)) ? r_cnt : CW'(PIXELS - 1);

  assign img_addr      = r_base + 20'(w_off);
  assign lbl_addr      = r_idx;
  assign data_out      = r_data;
  assign valid_out     = r_valid;
  assign hit_count     = r_hit;
  assign img_count     = r_img;
  assign timeout_count = r_tmo;
  assign busy          = (r_state == STREAM) || (r_state == WAIT)
                         || (r_state == CHECK);
  assign done          = (r_state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_next = STREAM;
      STREAM:     if (w_str_end) w_next = WAIT;
      WAIT:       if (pred_valid || w_wd_hit) w_next = CHECK;
      CHECK:      w_next = w_last ? DONE : STREAM;
      default:    w_next = IDLE;
    endcase
  end

  // Image index, pixel counter, label/prediction capture and scoring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_base  <= '0;
      r_idx   <= '0;
      r_label <= '0;
      r_pred  <= '0;
      r_to    <= 1'b0;
      r_wd    <= '0;
      r_hit   <= '0;
      r_img   <= '0;
      r_tmo   <= '0;
    end else if (w_start) begin
      r_cnt  <= '0;
      r_base <= '0;
      r_idx  <= '0;
      r_hit  <= '0;
      r_img  <= '0;
      r_tmo  <= '0;
    end else begin
      unique case (r_state)
        STREAM: begin
          if (!w_str_end) r_cnt <= r_cnt + CW'(1);
          if (r_cnt != '0) r_label <= lbl_data;
          r_wd <= '0;
          r_to <= 1'b0;
        end
        WAIT: begin
          if (pred_valid) r_pred <= pred_in;
          else if (w_wd_hit) r_to <= 1'b1;
          else r_wd <= r_wd + WW'(1);
        end
        CHECK: begin
          r_img <= r_img + 10'd1;
          if (r_to) r_tmo <= r_tmo + 10'd1;
          else if (r_pred == r_label) r_hit <= r_hit + 10'd1;
          if (!w_last) begin
            r_idx  <= r_idx + 10'd1;
            r_base <= r_base + 20'(PIXELS);
            r_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Two-stage pixel pipe: ROM read latency, then registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 1'b0;
    end else begin
      r_rd_v  <= (r_state == STREAM) && (r_cnt < CW'(PIXELS));
      r_valid <= r_rd_v;
      r_data  <= r_rd_v & img_bit;
    end
  end

endmodule

// File: tb/tb_mnist_batch_driver.sv
// tb_mnist_batch_driver: randomized ROM contents and predictions scored against a batch model.
// Watchdog scenario follows BATCH_WATCHDOG_EN when it is defined for the build.
module tb_mnist_batch_driver;

  localparam int NI = 4;
  localparam int NP = 8;
  localparam int TO = 50;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] img_addr;
  logic        img_bit;
  logic [9:0]  lbl_addr;
  logic [3:0]  lbl_data;
  logic        data_out;
  logic        valid_out;
  logic [3:0]  pred_in;
  logic        pred_valid;
  logic [9:0]  hit_count;
  logic [9:0]  img_count;
  logic [9:0]  timeout_count;
  logic        busy;
  logic        done;

  logic        rom_img [0:NI*NP-1];
  logic [3:0]  rom_lbl [0:NI-1];

  int n_chk;
  int n_fail;

  mnist_batch_driver #(
    .NUM_IMAGES(NI),
    .PIXELS(NP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .img_addr(img_addr),
    .img_bit(img_bit),
    .lbl_addr(lbl_addr),
    .lbl_data(lbl_data),
    .data_out(data_out),
    .valid_out(valid_out),
    .pred_in(pred_in),
    .pred_valid(pred_valid),
    .hit_count(hit_count),
    .img_count(img_count),
    .timeout_count(timeout_count),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    img_bit  <= rom_img[img_addr[4:0]];
    lbl_data <= rom_lbl[lbl_addr[1:0]];
  end

  task automatic fill_rom();
    for (int i = 0; i < NI*NP; i++) rom_img[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < NI; i++) rom_lbl[i] = 4'($urandom_range(0, 9));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pred_valid = 1'b0;
    pred_in = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_pred(input logic [3:0] p);
    pred_in = p;
    pred_valid = 1'b1;
    @(negedge clk);
    pred_valid = 1'b0;
  endtask

  task automatic chk10(input string nm, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic stream_image(input int idx, input bit send, input logic [3:0] pred, input bit stray);
    int n = 0;
    while (valid_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_start img %0d: valid_out=%b required 1 within 20 cycles", idx, valid_out);
    end
    chk10("lbl_addr", lbl_addr, 10'(idx));
    for (int k = 0; k < NP; k++) begin
      n_chk++;
      if (valid_out !== 1'b1 || data_out !== rom_img[idx*NP+k]) begin
        n_fail++;
        $display("FAIL pixel img %0d px %0d: valid=%b data=%b required valid=1 data=%b",
                 idx, k, valid_out, data_out, rom_img[idx*NP+k]);
      end
      if (stray && (k == 2 || k == NP-1)) begin
        pred_in = rom_lbl[idx];
        pred_valid = 1'b1;
      end
      @(negedge clk);
      pred_valid = 1'b0;
    end
    n_chk++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_end img %0d: valid_out=%b required 0", idx, valid_out);
    end
    if (send) pulse_pred(pred);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pred_valid = 1'b0;
    pred_in = 4'd0;
    repeat (2) @(negedge clk);
    chk10("rst img_addr", 10'(img_addr), 10'd0);
    chk10("rst lbl_addr", lbl_addr, 10'd0);
    chk10("rst hit", hit_count, 10'd0);
    chk10("rst img", img_count, 10'd0);
    chk10("rst tmo", timeout_count, 10'd0);
    chk10("rst flags", {6'd0, busy, done, valid_out, data_out}, 10'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk10("idle flags", {6'd0, busy, done, valid_out, data_out}, 10'd0);
  endtask

  task automatic test_stream();
    fill_rom();
    apply_reset();
    pulse_start();
    chk10("entry busy", {9'd0, busy}, 10'd1);
    for (int k = 0; k <= NP + 2; k++) begin
      if (k < NP) chk10("stream addr", 10'(img_addr), 10'(k));
      chk10("valid timing", {9'd0, valid_out}, (k >= 2 && k < NP + 2) ? 10'd1 : 10'd0);
      if (k >= 2 && k < NP + 2)
        chk10("stream data", {9'd0, data_out}, {9'd0, rom_img[k-2]});
      @(negedge clk);
    end
  endtask

  task automatic run_batch(input logic [3:0] preds [0:NI-1], input string tag);
    int exp_hit = 0;
    for (int i = 0; i < NI; i++) if (preds[i] == rom_lbl[i]) exp_hit++;
    apply_reset();
    pulse_start();
    for (int i = 0; i < NI; i++) stream_image(i, 1'b1, preds[i], 1'b0);
    @(negedge clk);
    chk10({tag, " done"}, {8'd0, done, busy}, 10'd2);
    chk10({tag, " hit"}, hit_count, 10'(exp_hit));
    chk10({tag, " img"}, img_count, 10'(NI));
    chk10({tag, " tmo"}, timeout_count, 10'd0);
  endtask

  task automatic test_batch_fixed();
    logic [3:0] preds [0:NI-1];
    fill_rom();
    rom_lbl[0] = 4'd3; rom_lbl[1] = 4'd7; rom_lbl[2] = 4'd1; rom_lbl[3] = 4'd0;
    preds[0] = 4'd3; preds[1] = 4'd2; preds[2] = 4'd1; preds[3] = 4'd0;
    run_batch(preds, "fixed");
  endtask

  task automatic test_batch_random();
    logic [3:0] preds [0:NI-1];
    for (int r = 0; r < 3; r++) begin
      fill_rom();
      for (int i = 0; i < NI; i++)
        preds[i] = ($urandom_range(0, 1) == 1) ? rom_lbl[i] : 4'($urandom_range(0, 15));
      run_batch(preds, "random");
    end
  endtask

  task automatic test_ignore_pred();
    fill_rom();
    apply_reset();
    pulse_start();
    stream_image(0, 1'b1, rom_lbl[0] ^ 4'd1, 1'b1);
    @(negedge clk);
    chk10("ign img", img_count, 10'd1);
    chk10("ign hit", hit_count, 10'd0);
    stream_image(1, 1'b0, 4'd0, 1'b1);
    repeat (10) @(negedge clk);
    chk10("ign wait img", img_count, 10'd1);
    chk10("ign wait busy", {9'd0, busy}, 10'd1);
    pulse_pred(rom_lbl[1]);
    @(negedge clk);
    chk10("ign img2", img_count, 10'd2);
    chk10("ign hit2", hit_count, 10'd1);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fill_rom();
    apply_reset();
    pulse_start();
    stream_image(0, 1'b1, rom_lbl[0], 1'b0);
    stream_image(1, 1'b1, rom_lbl[1], 1'b0);
    while (valid_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk10("mid valid", {9'd0, valid_out}, 10'd1);
    chk10("mid hit pre", hit_count, 10'd2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk10("mid img_addr", 10'(img_addr), 10'd0);
    chk10("mid lbl_addr", lbl_addr, 10'd0);
    chk10("mid hit", hit_count, 10'd0);
    chk10("mid img", img_count, 10'd0);
    chk10("mid tmo", timeout_count, 10'd0);
    chk10("mid flags", {6'd0, busy, done, valid_out, data_out}, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    chk10("restart addr", 10'(img_addr), 10'd0);
    chk10("restart img", img_count, 10'd0);
    chk10("restart busy", {9'd0, busy}, 10'd1);
    stream_image(0, 1'b1, rom_lbl[0], 1'b0);
    @(negedge clk);
    chk10("restart img1", img_count, 10'd1);
  endtask

  task automatic test_watchdog();
    fill_rom();
    apply_reset();
    pulse_start();
    stream_image(0, 1'b1, rom_lbl[0], 1'b0);
    stream_image(1, 1'b0, 4'd0, 1'b0);
`ifdef BATCH_WATCHDOG_EN
    repeat (TO) @(negedge clk);
    chk10("wd pre tmo", timeout_count, 10'd0);
    @(negedge clk);
    chk10("wd tmo", timeout_count, 10'd1);
    chk10("wd img", img_count, 10'd2);
    chk10("wd hit", hit_count, 10'd1);
    chk10("wd resume addr", 10'(img_addr), 10'd16);
    stream_image(2, 1'b1, rom_lbl[2], 1'b0);
    stream_image(3, 1'b1, rom_lbl[3], 1'b0);
    @(negedge clk);
    chk10("wd final hit", hit_count, 10'd3);
    chk10("wd final tmo", timeout_count, 10'd1);
`else
    repeat (TO + 10) @(negedge clk);
    chk10("nowd img", img_count, 10'd1);
    chk10("nowd tmo", timeout_count, 10'd0);
    chk10("nowd busy", {9'd0, busy}, 10'd1);
    pulse_pred(rom_lbl[1]);
    @(negedge clk);
    chk10("nowd img2", img_count, 10'd2);
    stream_image(2, 1'b1, rom_lbl[2], 1'b0);
    stream_image(3, 1'b1, rom_lbl[3], 1'b0);
    @(negedge clk);
    chk10("nowd final hit", hit_count, 10'd4);
    chk10("nowd final tmo", timeout_count, 10'd0);
`endif
    chk10("wdog done", {9'd0, done}, 10'd1);
  endtask

  task automatic test_restart();
    fill_rom();
    apply_reset();
    pulse_start();
    for (int i = 0; i < NI; i++) stream_image(i, 1'b1, rom_lbl[i], 1'b0);
    @(negedge clk);
    chk10("rs done", {9'd0, done}, 10'd1);
    chk10("rs hit pre", hit_count, 10'd4);
    start = 1'b1;
    @(negedge clk);
    chk10("rs busy", {8'd0, busy, done}, 10'd2);
    chk10("rs hit clr", hit_count, 10'd0);
    chk10("rs img clr", img_count, 10'd0);
    stream_image(0, 1'b1, rom_lbl[0], 1'b0);
    @(negedge clk);
    chk10("rs held img", img_count, 10'd1);
    start = 1'b0;
    for (int i = 1; i < NI; i++) stream_image(i, 1'b1, 4'(rom_lbl[i] + 4'd1), 1'b0);
    @(negedge clk);
    chk10("rs final hit", hit_count, 10'd1);
    chk10("rs final done", {9'd0, done}, 10'd1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    fill_rom();
    test_reset();
    test_stream();
    test_batch_fixed();
    test_batch_random();
    test_ignore_pred();
    test_reset_mid();
    test_watchdog();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
